rv_irq_arbiter: RTL and testbench

RV_IRQ_ARBITER -- requirements
Module: rv_irq_arbiter

---
 rtl/rv_irq_pkg.sv | 34 +++
 rtl/rv_irq_prio_tree.sv | 40 ++++
 rtl/rv_irq_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_rv_irq_arbiter.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_irq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rv_irq_pkg
// Description : Shared constants for the rv_irq_arbiter interrupt arbiter:
//               register byte offsets, interrupt ID width, the priority field
//               type and a source-index to interrupt-ID helper.
// Revision    : 1.0 - initial release
// ============================================================================
package rv_irq_pkg;

    // Interrupt IDs are 5 bits wide. ID 0 means "no interrupt", so source
    // index i is reported as ID i+1.
    localparam int ID_W = 5;

    // Register byte offsets
    localparam logic [7:0] REG_PENDING   = 8'h00;
    localparam logic [7:0] REG_ENABLE    = 8'h04;
    localparam logic [7:0] REG_EDGE      = 8'h08;
    localparam logic [7:0] REG_THRESHOLD = 8'h0C;
    localparam logic [7:0] REG_CLAIM     = 8'h10;
    localparam logic [7:0] REG_PRIO_BASE = 8'h40;

    // Priority field type for the default PRIO_W of 3. Modules that are
    // built with a different PRIO_W declare logic [PRIO_W-1:0] directly.
    localparam int DEF_PRIO_W = 3;
    typedef logic [DEF_PRIO_W-1:0] prio_t;

    // Convert a zero-based source index into its interrupt ID
    function automatic logic [ID_W-1:0] src_id(input int idx);
        return ID_W'(idx + 1);
    endfunction

endpackage : rv_irq_pkg
`default_nettype wire

// File: rtl/rv_irq_prio_tree.sv
`default_nettype none
// ============================================================================
// Module      : rv_irq_prio_tree
// Description : Combinational winner selection. Among the eligible sources,
//               picks the one with the highest priority; equal priorities
//               resolve to the lowest source index. Outputs the winner's
//               interrupt ID (index+1), or 0 when nothing is eligible.
// Revision    : 1.0 - initial release
// ============================================================================
module rv_irq_prio_tree
    import rv_irq_pkg::*;
#(
    parameter int NUM_SRC = 8,
    parameter int PRIO_W  = 3
) (
    input  logic [NUM_SRC-1:0]             elig_i,
    input  logic [NUM_SRC-1:0][PRIO_W-1:0] prio_i,
    output logic [ID_W-1:0]                id_o
);

    logic [PRIO_W-1:0] best_prio;
    logic [ID_W-1:0]   best_id;

    // Scan from the lowest index upwards; only a strictly greater priority
    // replaces the current winner, so ties keep the lower index.
    always_comb begin
        best_prio = '0;
        best_id   = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (elig_i[i] && ((best_id == '0) || (prio_i[i] > best_prio))) begin
                best_prio = prio_i[i];
                best_id   = src_id(i);
            end
        end
    end

    assign id_o = best_id;

endmodule : rv_irq_prio_tree
`default_nettype wire

// File: rtl/rv_irq_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rv_irq_arbiter
// Description : Platform-level interrupt arbiter for NUM_SRC sources with
//               per-source edge/level mode, enable, priority, a global
//               threshold and a claim/complete handshake. Drives a registered
//               ext_irq and the registered ID of the winning source.
//               Build option RV_IRQ_SYNC_EN: pass every irq_src bit through a
//               2-flop synchroniser (adds 2 cycles of input latency).
// Revision    : 1.0 - initial release
// ============================================================================
module rv_irq_arbiter
    import rv_irq_pkg::*;
#(
    parameter int NUM_SRC = 8,
    parameter int PRIO_W  = 3
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_SRC-1:0] irq_src,
    input  logic [7:0]         reg_addr,
    input  logic [31:0]        reg_wdata,
    input  logic               reg_write,
    input  logic               reg_read,
    output logic [31:0]        reg_rdata,
    output logic               ext_irq,
    output logic [ID_W-1:0]    best_id
);

    logic [NUM_SRC-1:0]             src_s;
    logic [NUM_SRC-1:0]             hist_q;
    logic [NUM_SRC-1:0]             pending_q, pending_d;
    logic [NUM_SRC-1:0]             in_service_q, in_service_d;
    logic [NUM_SRC-1:0]             enable_q, edge_q;
    logic [PRIO_W-1:0]              thresh_q;
    logic [NUM_SRC-1:0][PRIO_W-1:0] prio_q;
    logic [ID_W-1:0]                best_id_q, win_id;
    logic                           ext_irq_q;

`ifdef RV_IRQ_SYNC_EN
    logic [NUM_SRC-1:0] sync1_q, sync2_q;

    // Two-flop synchroniser for sources that are asynchronous to clk
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= irq_src;
            sync2_q <= sync1_q;
        end
    end

    assign src_s = sync2_q;
`else
    assign src_s = irq_src;
`endif

    // ---------------------------------------------------------------- decode
    logic       sel_enable, sel_edge, sel_thresh, sel_claim, prio_hit;
    logic [7:0] prio_off;
    logic [5:0] prio_idx;

    assign sel_enable = (reg_addr == REG_ENABLE);
    assign sel_edge   = (reg_addr == REG_EDGE);
    assign sel_thresh = (reg_addr == REG_THRESHOLD);
    assign sel_claim  = (reg_addr == REG_CLAIM);
    assign prio_off   = reg_addr - REG_PRIO_BASE;
    assign prio_idx   = prio_off[7:2];
    assign prio_hit   = (reg_addr >= REG_PRIO_BASE) && (prio_off[1:0] == 2'b00)
                        && ({2'b00, prio_idx} < 8'(NUM_SRC));

    // ------------------------------------------------------ claim / complete
    logic               claim, complete;
    logic [ID_W-1:0]    comp_id;
    logic [NUM_SRC-1:0] claim_mask, comp_mask, rise, above_thr, elig;

    // A claim only has side effects when there is a winner to hand out
    assign claim    = reg_read && sel_claim && (best_id_q != '0);
    assign complete = reg_write && sel_claim;
    assign comp_id  = reg_wdata[ID_W-1:0];

    // One-hot decode of claimed/completed IDs and per-source threshold compare.
    // IDs 0 and > NUM_SRC match no source, so they fall out naturally.
    always_comb begin
        claim_mask = '0;
        comp_mask  = '0;
        above_thr  = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            claim_mask[i] = claim && (best_id_q == src_id(i));
            comp_mask[i]  = complete && (comp_id == src_id(i));
            above_thr[i]  = (prio_q[i] > thresh_q);
        end
    end

    // Edge sources latch a rising edge until claimed (a new edge wins over a
    // simultaneous claim); level sources simply follow the input.
    assign rise         = src_s & ~hist_q;
    assign pending_d    = (edge_q & ((pending_q & ~claim_mask) | rise)) | (~edge_q & src_s);
    // Completing a source that is not in service clears nothing
    assign in_service_d = (in_service_q & ~comp_mask) | claim_mask;
    assign elig         = pending_q & enable_q & ~in_service_q & above_thr;

    // Pending, in-service and edge-detect history state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hist_q       <= '0;
            pending_q    <= '0;
            in_service_q <= '0;
        end else begin
            hist_q       <= src_s;
            pending_q    <= pending_d;
            in_service_q <= in_service_d;
        end
    end

    // Software-programmable configuration registers, truncated to field width
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            enable_q <= '0;
            edge_q   <= '0;
            thresh_q <= '0;
            prio_q   <= '0;
        end else if (reg_write) begin
            if (sel_enable) enable_q <= reg_wdata[NUM_SRC-1:0];
            if (sel_edge)   edge_q   <= reg_wdata[NUM_SRC-1:0];
            if (sel_thresh) thresh_q <= reg_wdata[PRIO_W-1:0];
            for (int i = 0; i < NUM_SRC; i++) begin
                if (prio_hit && (prio_idx == 6'(i))) begin
                    prio_q[i] <= reg_wdata[PRIO_W-1:0];
                end
            end
        end
    end

    rv_irq_prio_tree #(
        .NUM_SRC (NUM_SRC),
        .PRIO_W  (PRIO_W)
    ) u_prio_tree (
        .elig_i (elig),
        .prio_i (prio_q),
        .id_o   (win_id)
    );

    // Register the winner one cycle after eligibility settles
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            best_id_q <= '0;
            ext_irq_q <= 1'b0;
        end else begin
            best_id_q <= win_id;
            ext_irq_q <= (win_id != '0);
        end
    end

    assign best_id = best_id_q;
    assign ext_irq = ext_irq_q;

    // Combinational read mux; the bus reads 0 when no read is in progress
    always_comb begin
        reg_rdata = '0;
        if (reg_read) begin
            case (reg_addr)
                REG_PENDING:   reg_rdata = 32'(pending_q);
                REG_ENABLE:    reg_rdata = 32'(enable_q);
                REG_EDGE:      reg_rdata = 32'(edge_q);
                REG_THRESHOLD: reg_rdata = 32'(thresh_q);
                REG_CLAIM:     reg_rdata = 32'(best_id_q);
                default: begin
                    for (int i = 0; i < NUM_SRC; i++) begin
                        if (prio_hit && (prio_idx == 6'(i))) begin
                            reg_rdata = 32'(prio_q[i]);
                        end
                    end
                end
            endcase
        end
    end

    // Write-data bits above the widest field are intentionally ignored
    logic unused_wdata;
    assign unused_wdata = ^reg_wdata;

endmodule : rv_irq_arbiter
`default_nettype wire

// File: tb/tb_rv_irq_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_rv_irq_arbiter
// Description : Self-checking bench for rv_irq_arbiter: directed scenarios
//               with literal expectations, then randomized traffic compared
//               every cycle against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rv_irq_arbiter;

    localparam int N    = 8;
    localparam int PW   = 3;
    localparam int PMAX = (1 << PW) - 1;
`ifdef RV_IRQ_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic         clk       = 1'b0;
    logic         reset_n   = 1'b0;
    logic [N-1:0] irq_src   = '0;
    logic [7:0]   reg_addr  = '0;
    logic [31:0]  reg_wdata = '0;
    logic         reg_write = 1'b0;
    logic         reg_read  = 1'b0;
    logic [31:0]  reg_rdata;
    logic         ext_irq;
    logic [4:0]   best_id;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    rv_irq_arbiter #(.NUM_SRC(N), .PRIO_W(PW)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .irq_src   (irq_src),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_write (reg_write),
        .reg_read  (reg_read),
        .reg_rdata (reg_rdata),
        .ext_irq   (ext_irq),
        .best_id   (best_id)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------ behavioural model
    bit [N-1:0] m_pend, m_en, m_edge, m_insvc, m_prev, m_s1, m_s2;
    int         m_thr, m_best;
    int         m_prio [N];

    // Highest priority level above threshold first, then lowest index
    function automatic int winner();
        for (int p = PMAX; p > m_thr; p--)
            for (int i = 0; i < N; i++)
                if (m_pend[i] && m_en[i] && !m_insvc[i] && m_prio[i] == p) return i + 1;
        return 0;
    endfunction

    function automatic int model_read(input logic [7:0] a);
        int ai;
        ai = int'(a);
        if (ai == 0)  return int'(m_pend);
        if (ai == 4)  return int'(m_en);
        if (ai == 8)  return int'(m_edge);
        if (ai == 12) return m_thr;
        if (ai == 16) return m_best;
        if (ai >= 64 && ai % 4 == 0 && (ai - 64) / 4 < N) return m_prio[(ai - 64) / 4];
        return 0;
    endfunction

    always @(posedge clk or negedge reset_n) begin : model
        bit [N-1:0] seen, clm, cmp;
        int id, ai;
        if (!reset_n) begin
            m_pend <= '0; m_en <= '0; m_edge <= '0; m_insvc <= '0;
            m_prev <= '0; m_s1 <= '0; m_s2 <= '0;
            m_thr  <= 0;  m_best <= 0;
            for (int i = 0; i < N; i++) m_prio[i] <= 0;
        end else begin
            seen = (LAT != 0) ? m_s2 : irq_src;
            clm  = '0;
            cmp  = '0;
            if (reg_read && reg_addr == 8'h10 && m_best != 0) clm[m_best - 1] = 1'b1;
            id = int'(reg_wdata[4:0]);
            if (reg_write && reg_addr == 8'h10 && id >= 1 && id <= N) cmp[id - 1] = m_insvc[id - 1];
            for (int i = 0; i < N; i++)
                m_pend[i] <= m_edge[i] ? ((m_pend[i] && !clm[i]) || (seen[i] && !m_prev[i])) : seen[i];
            m_insvc <= (m_insvc & ~cmp) | clm;
            m_best  <= winner();
            m_prev  <= seen;
            m_s2    <= m_s1;
            m_s1    <= irq_src;
            if (reg_write) begin
                ai = int'(reg_addr);
                if (ai == 4)       m_en   <= reg_wdata[N-1:0];
                else if (ai == 8)  m_edge <= reg_wdata[N-1:0];
                else if (ai == 12) m_thr  <= int'(reg_wdata[PW-1:0]);
                else if (ai >= 64 && ai % 4 == 0 && (ai - 64) / 4 < N)
                    m_prio[(ai - 64) / 4] <= int'(reg_wdata[PW-1:0]);
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        chk("best_id", 32'(best_id), m_best);
        chk("ext_irq", 32'(ext_irq), 32'(m_best != 0));
        chk("reg_rdata", reg_rdata, reg_read ? model_read(reg_addr) : 0);
    end

    // ------------------------------------------------------------ bus helpers
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        reg_addr = a; reg_wdata = d; reg_write = 1'b1;
        tick();
        reg_write = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, output logic [31:0] d);
        reg_addr = a; reg_read = 1'b1;
        #2 d = reg_rdata;
        tick();
        reg_read = 1'b0;
    endtask

    function automatic logic [7:0] pick_addr();
        int k;
        k = int'($urandom_range(15));
        if (k < 4)   return 8'(4 * k);
        if (k < 12)  return 8'(64 + 4 * (k - 4));
        if (k == 12) return 8'h60;
        if (k == 13) return 8'h14;
        if (k == 14) return 8'h42;
        return 8'hFC;
    endfunction

    // ---------------------------------------------------------------- stimulus
    initial begin
        logic [31:0] d;
        logic [7:0]  rst_addrs [4];
        int          cool;
        int          r;
        int          b;

        // Reset state
        tick(2);
        chk("rst_best", 32'(best_id), 0);
        chk("rst_ext", 32'(ext_irq), 0);
        reset_n = 1'b1;
        tick();
        rd(8'h04, d); chk("rst_enable", d, 0);
        rd(8'h48, d); chk("rst_prio2", d, 0);

        // Source 3 edge, prio 5, threshold 2
        wr(8'h04, 32'h04);
        wr(8'h08, 32'h04);
        wr(8'h0C, 32'h2);
        wr(8'h48, 32'hFFFF_FFF5);
        rd(8'h48, d); chk("prio_trunc", d, 5);
        irq_src[2] = 1'b1; tick(); irq_src[2] = 1'b0; tick(LAT);
        chk("edge_lat_early", 32'(best_id), 0);
        tick();
        chk("edge_best", 32'(best_id), 3);
        chk("edge_ext", 32'(ext_irq), 1);

        // Claim 3, second edge while in service, bogus completes
        rd(8'h10, d); chk("claim_id", d, 3);
        tick(); chk("insvc_ext", 32'(ext_irq), 0);
        irq_src[2] = 1'b1; tick(); irq_src[2] = 1'b0; tick(LAT + 2);
        chk("insvc_edge_ext", 32'(ext_irq), 0);
        rd(8'h00, d); chk("insvc_pending", d, 32'h4);
        wr(8'h10, 32'd0); wr(8'h10, 32'd9); wr(8'h10, 32'd2); tick();
        chk("bad_complete_ext", 32'(ext_irq), 0);
        wr(8'h10, 32'd3); tick();
        chk("complete_best", 32'(best_id), 3);
        chk("complete_ext", 32'(ext_irq), 1);
        rd(8'h10, d); chk("reclaim_id", d, 3);
        wr(8'h10, 32'd3); tick();
        rd(8'h10, d); chk("claim_empty", d, 0);

        // Sources 1 and 4 tie at priority 4
        wr(8'h04, 32'h09);
        wr(8'h08, 32'h0D);
        wr(8'h40, 32'h4);
        wr(8'h4C, 32'h4);
        irq_src = 8'h09; tick(); irq_src = '0; tick(LAT + 1);
        chk("tie_best", 32'(best_id), 1);
        rd(8'h10, d); chk("tie_claim", d, 1);
        tick(); chk("next_best", 32'(best_id), 4);
        // Claim 4 and complete 1 together
        reg_addr = 8'h10; reg_wdata = 32'd1; reg_write = 1'b1; reg_read = 1'b1;
        #2 d = reg_rdata;
        tick();
        reg_write = 1'b0; reg_read = 1'b0;
        chk("sim_claim", d, 4);
        tick(); chk("sim_idle_ext", 32'(ext_irq), 0);
        irq_src[0] = 1'b1; tick(); irq_src[0] = 1'b0; tick(LAT + 1);
        chk("sim_complete_took", 32'(best_id), 1);

        // Level source 2, prio 1 vs threshold 1
        wr(8'h04, 32'h02);
        wr(8'h08, 32'h0D);
        wr(8'h44, 32'h1);
        wr(8'h0C, 32'h1);
        irq_src[1] = 1'b1; tick(LAT + 3);
        chk("lvl_thr_ext", 32'(ext_irq), 0);
        wr(8'h0C, 32'h0); tick();
        chk("lvl_best", 32'(best_id), 2);

        // Asynchronous reset with a claim outstanding
        rd(8'h10, d); chk("lvl_claim", d, 2);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_best", 32'(best_id), 0);
        chk("arst_ext", 32'(ext_irq), 0);
        rst_addrs[0] = 8'h00; rst_addrs[1] = 8'h04; rst_addrs[2] = 8'h0C; rst_addrs[3] = 8'h44;
        reg_read = 1'b1;
        for (int k = 0; k < 4; k++) begin
            reg_addr = rst_addrs[k];
            #1 chk("arst_reg", reg_rdata, 0);
        end
        reg_read = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        wr(8'h04, 32'h02);
        wr(8'h44, 32'h1);
        tick();
        chk("post_rst_best", 32'(best_id), 2);

        // Randomized traffic
        cool = 0;
        for (int c = 0; c < 4000; c++) begin
            reg_write = 1'b0;
            reg_read  = 1'b0;
            reset_n   = 1'b1;
            if (cool > 0) cool--;
            if ($urandom_range(7) == 0) begin
                b = int'($urandom_range(N - 1));
                irq_src[b] = ~irq_src[b];
            end
            r = int'($urandom_range(99));
            if (r < 12) begin
                reg_addr = pick_addr(); reg_wdata = $urandom(); reg_write = 1'b1;
            end else if (r < 22 && cool == 0) begin
                reg_addr = 8'h10; reg_read = 1'b1; cool = 2;
            end else if (r < 30) begin
                reg_addr = 8'h10; reg_wdata = 32'($urandom_range(10)); reg_write = 1'b1;
            end else if (r < 34 && cool == 0) begin
                reg_addr = 8'h10; reg_wdata = 32'($urandom_range(10));
                reg_write = 1'b1; reg_read = 1'b1; cool = 2;
            end else if (r < 50) begin
                reg_addr = pick_addr(); reg_read = 1'b1;
            end else if (r == 99 && $urandom_range(4) == 0) begin
                reset_n = 1'b0;
            end
            tick();
        end
        reg_write = 1'b0;
        reg_read  = 1'b0;
        reset_n   = 1'b1;
        tick(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule : tb_rv_irq_arbiter
`default_nettype wire
